forth_stack_unit: RTL and testbench

//  Parametrised hardware stack engine for the Forth core: NUM_STACKS independent LIFO stacks
//  (default 2: parameter + return) replacing memory-mapped PSP/RSP traffic. The stack selected by
//  i_SEL (SSR-equivalent) is pushed, popped, top-replaced or flushed over a valid/ready handshake,

---
 rtl/forth_stack_unit_pkg.sv | 21 ++
 rtl/forth_stack_unit_if.sv | 40 ++++
 rtl/forth_stack_unit_stack_ram.sv | 28 ++
 rtl/forth_stack_unit.sv | 137 +++++++++++++
 tb/tb_forth_stack_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/forth_stack_unit_pkg.sv
// Shared encodings for the Forth hardware stack unit: request opcodes,
// flush sequencer states and the stack-select width helper.
package forth_stack_unit_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/forth_stack_unit_if.sv
// Request/response bundle between the CPU core and the stack unit.
interface forth_stack_unit_if #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 16,
    parameter int NUM_STACKS = 2
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int SEL_W = forth_stack_unit_pkg::sel_width(NUM_STACKS);

    logic [SEL_W-1:0]  i_SEL;
    logic              i_VALID;
    logic              o_READY;
    logic [1:0]        i_OP;
    logic              i_FLUSH;
    logic [DATA_W-1:0] i_DATA;
    logic [PTR_W-2:0]  i_PICK;
    logic              i_CLRERR;
    logic [DATA_W-1:0] o_TOS;
    logic [DATA_W-1:0] o_NOS;
    logic [DATA_W-1:0] o_PICK;
    logic [PTR_W-1:0]  o_DEPTH;
    logic              f_FULL;
    logic              f_EMPTY;
    logic              f_OVERFLOW;
    logic              f_UNDERFLOW;
    logic              f_BADSEL;

    modport master (
        output i_SEL, i_VALID, i_OP, i_FLUSH, i_DATA, i_PICK, i_CLRERR,
        input  o_READY, o_TOS, o_NOS, o_PICK, o_DEPTH,
               f_FULL, f_EMPTY, f_OVERFLOW, f_UNDERFLOW, f_BADSEL
    );

    modport slave (
        input  i_SEL, i_VALID, i_OP, i_FLUSH, i_DATA, i_PICK, i_CLRERR,
        output o_READY, o_TOS, o_NOS, o_PICK, o_DEPTH,
               f_FULL, f_EMPTY, f_OVERFLOW, f_UNDERFLOW, f_BADSEL
    );

endinterface

// File: rtl/forth_stack_unit_stack_ram.sv
// Cell storage for one stack: one synchronous write port, three
// asynchronous read ports (TOS, NOS, PICK). Contents are not reset.
module stack_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    input  logic [$clog2(DEPTH)-1:0] raddr_c,
    output logic [DATA_W-1:0]        rdata_a,
    output logic [DATA_W-1:0]        rdata_b,
    output logic [DATA_W-1:0]        rdata_c
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
    assign rdata_c = mem[raddr_c];

endmodule

// File: rtl/forth_stack_unit.sv
// NUM_STACKS independent LIFO stacks with push/pop/replace/flush over a
// valid/ready handshake and combinational TOS/NOS/PICK reads.
module forth_stack_unit
    import forth_stack_unit_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 16,
    parameter int NUM_STACKS = 2
) (
    input logic               clk,
    input logic               rst,
    forth_stack_unit_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int SEL_W = sel_width(NUM_STACKS);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e state, state_nx;
    logic [PTR_W-1:0] sp [NUM_STACKS];
    logic [SEL_W-1:0] flush_sel, sel;
    logic [AW-1:0]    flush_cnt, waddr, tos_addr, nos_addr, pick_addr;
    logic [DATA_W-1:0] wdata;
    logic [NUM_STACKS-1:0] we;
    logic [NUM_STACKS-1:0][DATA_W-1:0] rd_tos, rd_nos, rd_pick;
    logic [PTR_W-1:0] depth, tos_ptr, nos_ptr, pick_ptr, pick_ext;
    logic sel_ok, ready, accept, req, full, empty, flush_done;
    logic is_flush, is_push, is_pop, is_rep;
    logic ovf, unf, badsel;

    // Out-of-range selects read as an empty stack; a stack mid-flush reads as empty too.
    assign sel_ok     = int'(bus.i_SEL) < NUM_STACKS;
    assign sel        = sel_ok ? bus.i_SEL : '0;
    assign depth      = (!sel_ok || (state == ST_FLUSH && flush_sel == sel)) ? '0 : sp[sel];
    assign full       = depth == PTR_W'(DEPTH);
    assign empty      = depth == '0;
    assign pick_ext   = {1'b0, bus.i_PICK};
    assign tos_ptr    = depth - PTR_W'(1);
    assign nos_ptr    = depth - PTR_W'(2);
    assign pick_ptr   = tos_ptr - pick_ext;
    assign tos_addr   = tos_ptr[AW-1:0];
    assign nos_addr   = nos_ptr[AW-1:0];
    assign pick_addr  = pick_ptr[AW-1:0];

    assign ready      = state == ST_IDLE;
    assign accept     = bus.i_VALID && ready;
    assign req        = accept && sel_ok;
    assign is_flush   = req && bus.i_FLUSH;
    assign is_push    = req && !bus.i_FLUSH && (bus.i_OP == OP_PUSH);
    assign is_pop     = req && !bus.i_FLUSH && (bus.i_OP == OP_POP);
    assign is_rep     = req && !bus.i_FLUSH && (bus.i_OP == OP_REPLACE);
    assign flush_done = (state == ST_FLUSH) && (flush_cnt == LAST);

    always_comb begin
        state_nx = state;
        we       = '0;
        waddr    = tos_addr;
        wdata    = bus.i_DATA;
        case (state)
            ST_IDLE: begin
                if (is_flush) begin
                    state_nx = ST_FLUSH;
                end else if (is_push && !full) begin
                    we[sel] = 1'b1;
                    waddr   = depth[AW-1:0];
                end else if (is_rep && !empty) begin
                    we[sel] = 1'b1;
                end
            end
            ST_FLUSH: begin
                we[flush_sel] = 1'b1;
                waddr         = flush_cnt;
                wdata         = '0;
                if (flush_done) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            flush_sel <= '0;
            flush_cnt <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            badsel    <= 1'b0;
            for (int i = 0; i < NUM_STACKS; i++) sp[i] <= '0;
        end else begin
            state <= state_nx;
            if (is_flush) begin
                flush_sel <= sel;
                flush_cnt <= '0;
            end else if (state == ST_FLUSH) begin
                flush_cnt <= flush_cnt + AW'(1);
            end
            ovf    <= (is_push && full) || (ovf && !bus.i_CLRERR);
            unf    <= ((is_pop || is_rep) && empty) || (unf && !bus.i_CLRERR);
            badsel <= accept && !sel_ok;
            for (int i = 0; i < NUM_STACKS; i++) begin
                if (flush_done && flush_sel == SEL_W'(i))
                    sp[i] <= '0;
                else if (we[i] && is_push)
                    sp[i] <= sp[i] + PTR_W'(1);
                else if (is_pop && !empty && sel == SEL_W'(i))
                    sp[i] <= sp[i] - PTR_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_STACKS; g++) begin : g_stack
        stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
            .clk     (clk),
            .we      (we[g]),
            .waddr   (waddr),
            .wdata   (wdata),
            .raddr_a (tos_addr),
            .raddr_b (nos_addr),
            .raddr_c (pick_addr),
            .rdata_a (rd_tos[g]),
            .rdata_b (rd_nos[g]),
            .rdata_c (rd_pick[g])
        );
    end

    assign bus.o_READY     = ready;
    assign bus.o_TOS       = empty ? '0 : rd_tos[sel];
    assign bus.o_NOS       = (depth >= PTR_W'(2)) ? rd_nos[sel] : '0;
    assign bus.o_PICK      = (pick_ext < depth) ? rd_pick[sel] : '0;
    assign bus.o_DEPTH     = depth;
    assign bus.f_FULL      = full;
    assign bus.f_EMPTY     = empty;
    assign bus.f_OVERFLOW  = ovf;
    assign bus.f_UNDERFLOW = unf;
    assign bus.f_BADSEL    = badsel;

endmodule

// File: tb/tb_forth_stack_unit.sv
// Directed bench for forth_stack_unit: a reference stack model feeds an
// expectation queue that is drained after each accepted request.
module tb_forth_stack_unit;
    import forth_stack_unit_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int NS     = 3;

    typedef struct {
        logic [15:0] tos;
        logic [4:0]  depth;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   lowcnt;

    exp_t        exp_q[$];
    logic [15:0] m_mem [NS][DEPTH];
    int          m_dep [NS];
    logic        m_ovf, m_unf;

    forth_stack_unit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_STACKS(NS)) bus ();

    forth_stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_STACKS(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int s, input logic [1:0] op, input logic [15:0] d);
        exp_t e;
        bus.i_SEL   = 2'(s);
        bus.i_OP    = op;
        bus.i_DATA  = d;
        bus.i_FLUSH = 1'b0;
        bus.i_VALID = 1'b1;
        case (op)
            OP_PUSH:    if (m_dep[s] == DEPTH) m_ovf = 1'b1;
                        else begin m_mem[s][m_dep[s]] = d; m_dep[s]++; end
            OP_POP:     if (m_dep[s] == 0) m_unf = 1'b1; else m_dep[s]--;
            OP_REPLACE: if (m_dep[s] == 0) m_unf = 1'b1; else m_mem[s][m_dep[s]-1] = d;
            default: ;
        endcase
        e.tos   = (m_dep[s] > 0) ? m_mem[s][m_dep[s]-1] : 16'h0;
        e.depth = 5'(m_dep[s]);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
        tick();
        bus.i_VALID = 1'b0;
        e = exp_q.pop_front();
        check("op_tos",   bus.o_TOS,       e.tos);
        check("op_depth", bus.o_DEPTH,     e.depth);
        check("op_ovf",   bus.f_OVERFLOW,  e.ovf);
        check("op_unf",   bus.f_UNDERFLOW, e.unf);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_SEL = '0; bus.i_VALID = 1'b0; bus.i_OP = OP_NOP; bus.i_FLUSH = 1'b0;
        bus.i_DATA = '0; bus.i_PICK = '0; bus.i_CLRERR = 1'b0;
        for (int i = 0; i < NS; i++) m_dep[i] = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_ready", bus.o_READY, 1);
        check("rst_depth", bus.o_DEPTH, 0);
        check("rst_tos",   bus.o_TOS, 0);
        check("rst_empty", bus.f_EMPTY, 1);
        check("rst_flags", {bus.f_OVERFLOW, bus.f_UNDERFLOW, bus.f_BADSEL}, 0);

        apply(0, OP_PUSH, 16'h1111);
        apply(0, OP_PUSH, 16'h2222);
        check("s0_tos2", bus.o_TOS, 16'h2222);
        check("s0_nos",  bus.o_NOS, 16'h1111);
        bus.i_SEL = 2'd1; #1;
        check("s1_depth0", bus.o_DEPTH, 0);
        check("s1_empty",  bus.f_EMPTY, 1);

        for (int i = 0; i < DEPTH; i++) apply(1, OP_PUSH, 16'h0100 + 16'(i));
        check("s1_full", bus.f_FULL, 1);
        apply(1, OP_PUSH, 16'hDEAD);
        check("s1_ovf_tos", bus.o_TOS, 16'h010F);
        check("s1_ovf",     bus.f_OVERFLOW, 1);

        apply(0, OP_POP, 16'h0);
        apply(0, OP_POP, 16'h0);
        apply(0, OP_POP, 16'h0);
        check("s0_unf", bus.f_UNDERFLOW, 1);
        apply(0, OP_REPLACE, 16'h3333);
        apply(0, OP_NOP, 16'h5555);
        bus.i_CLRERR = 1'b1;
        tick();
        bus.i_CLRERR = 1'b0;
        check("clr_ovf", bus.f_OVERFLOW, 0);
        check("clr_unf", bus.f_UNDERFLOW, 0);
        m_ovf = 1'b0; m_unf = 1'b0;

        for (int i = 1; i <= 5; i++) apply(0, OP_PUSH, 16'(i));
        bus.i_PICK = 4'd3; #1; check("pick3", bus.o_PICK, 16'd2);
        bus.i_PICK = 4'd5; #1; check("pick5", bus.o_PICK, 16'd0);
        bus.i_PICK = 4'd0; #1; check("pick0", bus.o_PICK, 16'd5);
        bus.i_PICK = 4'd4; #1; check("pick4", bus.o_PICK, 16'd1);
        bus.i_PICK = 4'd0;
        apply(0, OP_REPLACE, 16'hBEEF);
        check("rep_tos", bus.o_TOS, 16'hBEEF);
        check("rep_nos", bus.o_NOS, 16'd4);
        check("rep_dep", bus.o_DEPTH, 5);

        bus.i_SEL = 2'd3; bus.i_OP = OP_PUSH; bus.i_DATA = 16'h7777; bus.i_VALID = 1'b1;
        tick();
        bus.i_VALID = 1'b0;
        check("badsel_pulse", bus.f_BADSEL, 1);
        tick();
        check("badsel_clear", bus.f_BADSEL, 0);
        bus.i_SEL = 2'd2; #1;
        check("badsel_s2", bus.o_DEPTH, 0);
        bus.i_SEL = 2'd0; #1;
        check("badsel_s0", bus.o_DEPTH, 5);

        bus.i_FLUSH = 1'b1; bus.i_VALID = 1'b1;
        tick();
        bus.i_VALID = 1'b0; bus.i_FLUSH = 1'b0;
        check("flush_rd_dep", bus.o_DEPTH, 0);
        bus.i_SEL = 2'd1; #1;
        check("flush_s1_dep", bus.o_DEPTH, 16);
        bus.i_SEL = 2'd0; #1;
        lowcnt = 0;
        while (!bus.o_READY && lowcnt < 100) begin
            lowcnt++;
            tick();
        end
        check("flush_len", lowcnt, DEPTH);
        m_dep[0] = 0;
        check("flush_dep", bus.o_DEPTH, 0);
        check("flush_tos", bus.o_TOS, 0);
        bus.i_SEL = 2'd1; #1;
        check("flush_s1_keep", bus.o_DEPTH, 16);
        check("flush_s1_tos",  bus.o_TOS, 16'h010F);
        apply(0, OP_PUSH, 16'h0A0A);

        apply(1, OP_PUSH, 16'hDEAD);
        bus.i_SEL = 2'd0; bus.i_FLUSH = 1'b1; bus.i_VALID = 1'b1;
        tick();
        bus.i_VALID = 1'b0; bus.i_FLUSH = 1'b0;
        tick();
        tick();
        check("midflush_busy", bus.o_READY, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", bus.o_READY, 1);
        check("arst_s0",    bus.o_DEPTH, 0);
        check("arst_flags", {bus.f_OVERFLOW, bus.f_UNDERFLOW, bus.f_BADSEL}, 0);
        bus.i_SEL = 2'd1; #1;
        check("arst_s1", bus.o_DEPTH, 0);
        for (int i = 0; i < NS; i++) m_dep[i] = 0;
        m_ovf = 1'b0; m_unf = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        apply(0, OP_PUSH, 16'h1234);
        apply(0, OP_POP, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
